// File: rtl/pc_fetch_if.sv
// -----------------------------------------------------------------------------
// pc_fetch_if
//   Bundles the two handshakes of the fetch stage:
//     - instruction-memory request channel (req/ready, word address, read data)
//     - fetch-to-decode buffer channel (valid/ready, instruction, its PC)
//
//   Ports (signal : driven by the master = fetch stage, unless noted)
//     imem_req    : fetch request, held until imem_ready
//     imem_addr   : word address of the outstanding request
//     imem_ready  : (slave) memory completes the request this cycle
//     imem_rdata  : (slave) instruction word, valid with imem_ready
//     if_valid    : decode buffer holds an instruction
//     if_instr    : buffered instruction
//     if_pc       : address of if_instr
//     id_ready    : (slave) decode accepts the buffer this cycle
// -----------------------------------------------------------------------------
interface pc_fetch_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic        if_valid;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic        id_ready;

    // Fetch stage side.
    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ready,
        input  imem_rdata,
        output if_valid,
        output if_instr,
        output if_pc,
        input  id_ready
    );

    // Memory / decode side.
    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ready,
        output imem_rdata,
        input  if_valid,
        input  if_instr,
        input  if_pc,
        output id_ready
    );
endinterface

// File: rtl/pc_fetch.sv
// -----------------------------------------------------------------------------
// pc_fetch
//   Program counter and instruction-fetch stage. Holds the PC (fed to the
//   external PC+4 adder), selects between sequential / branch / jump /
//   exception targets, issues word fetches over a req/ready handshake and
//   presents fetched instructions to decode through a one-entry buffer.
//
//   Parameters
//     RESET_PC    : PC loaded on reset
//     EXC_VECTOR  : PC loaded on exc
//
//   Ports
//     clk, rst_n     : clock (rising edge), asynchronous active-low reset
//     pc             : current fetch PC, goes to the PC+4 adder
//     pc_plus4       : PC+4 adder result
//     branch_taken   : redirect pulse, target branch_target
//     jump           : redirect pulse, target jump_target
//     exc            : exception redirect pulse, target EXC_VECTOR
//     stall          : blocks the start of a new fetch
//     bus            : memory request + decode buffer channels (master)
//     fetch_cnt      : count of instructions accepted by decode (wraps)
//
//   All outputs come straight from registers.
// -----------------------------------------------------------------------------
module pc_fetch #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter logic [31:0] EXC_VECTOR = 32'h0000_0180
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic [31:0]       pc,
    input  logic [31:0]       pc_plus4,
    input  logic              branch_taken,
    input  logic [31:0]       branch_target,
    input  logic              jump,
    input  logic [31:0]       jump_target,
    input  logic              exc,
    input  logic              stall,
    pc_fetch_if.master        bus,
    output logic [31:0]       fetch_cnt
);

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        FETCH = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic        req_q, req_d;
    logic [31:0] addr_q, addr_d;
    logic        valid_q, valid_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] ifpc_q, ifpc_d;
    logic [31:0] cnt_q, cnt_d;

    logic        redirect;
    logic [31:0] target_sel;
    logic [31:0] target;
    logic        consume;
    logic        start_ok;

    // Redirect target, priority exc > jump > branch, word aligned.
    always_comb begin
        target_sel = branch_target;
        if (exc) begin
            target_sel = EXC_VECTOR;
        end else if (jump) begin
            target_sel = jump_target;
        end
        target = target_sel & ~32'h0000_0003;
    end

    assign redirect = exc | jump | branch_taken;
    assign consume  = valid_q & bus.id_ready;
    // Redirect is excluded separately at each use so a redirect never starts
    // a wrong-path fetch.
    assign start_ok = ~stall & (~valid_q | bus.id_ready);

    // Next-state and datapath.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        req_d   = req_q;
        addr_d  = addr_q;
        valid_d = valid_q;
        instr_d = instr_q;
        ifpc_d  = ifpc_q;
        cnt_d   = cnt_q;

        // Decode takes the buffer; a completion below may refill it.
        if (consume) begin
            valid_d = 1'b0;
            cnt_d   = cnt_q + 32'd1;
        end

        case (state_q)
            BOOT: begin
                state_d = FETCH;
                if (redirect) begin
                    pc_d = target;
                end
            end

            FETCH: begin
                if (redirect) begin
                    pc_d    = target;
                    valid_d = 1'b0;
                    if (req_q && !bus.imem_ready) begin
                        // Request must still be honoured; its data is dropped.
                        state_d = DRAIN;
                    end else begin
                        req_d = 1'b0;
                    end
                end else if (req_q) begin
                    if (bus.imem_ready) begin
                        instr_d = bus.imem_rdata;
                        ifpc_d  = addr_q;
                        valid_d = 1'b1;
                        pc_d    = pc_plus4;
                        // Chain the next request in the completion cycle so a
                        // zero-wait memory streams one word per cycle; the
                        // next address is the freshly advanced PC.
                        if (start_ok) begin
                            req_d  = 1'b1;
                            addr_d = pc_plus4;
                        end else begin
                            req_d = 1'b0;
                        end
                    end
                end else if (start_ok) begin
                    req_d  = 1'b1;
                    addr_d = pc_q;
                end
            end

            DRAIN: begin
                if (redirect) begin
                    pc_d    = target;
                    valid_d = 1'b0;
                end
                if (bus.imem_ready) begin
                    req_d   = 1'b0;
                    state_d = FETCH;
                end
            end

            default: begin
                state_d = BOOT;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= BOOT;
            pc_q    <= RESET_PC;
            req_q   <= 1'b0;
            addr_q  <= '0;
            valid_q <= 1'b0;
            instr_q <= '0;
            ifpc_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            req_q   <= req_d;
            addr_q  <= addr_d;
            valid_q <= valid_d;
            instr_q <= instr_d;
            ifpc_q  <= ifpc_d;
            cnt_q   <= cnt_d;
        end
    end

    assign pc           = pc_q;
    assign bus.imem_req = req_q;
    assign bus.imem_addr = addr_q;
    assign bus.if_valid = valid_q;
    assign bus.if_instr = instr_q;
    assign bus.if_pc    = ifpc_q;
    assign fetch_cnt    = cnt_q;

endmodule

// File: tb/tb_pc_fetch.sv
// -----------------------------------------------------------------------------
// tb_pc_fetch
//   Directed, table-driven bench for pc_fetch. The bench provides the PC+4
//   adder and a memory returning address ^ 32'hA5A5_A5A5.
// -----------------------------------------------------------------------------
module tb_pc_fetch;

    localparam logic [31:0] RST_PC = 32'h0040_0000;
    localparam logic [31:0] EXC_V  = 32'h0000_0180;
    localparam logic [31:0] XMASK  = 32'hA5A5_A5A5;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        branch_taken = 1'b0;
    logic [31:0] branch_target = '0;
    logic        jump = 1'b0;
    logic [31:0] jump_target = '0;
    logic        exc = 1'b0;
    logic        stall = 1'b0;
    logic [31:0] fetch_cnt;

    int checks = 0;
    int failures = 0;

    pc_fetch_if bus ();

    pc_fetch #(
        .RESET_PC   (RST_PC),
        .EXC_VECTOR (EXC_V)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .pc            (pc),
        .pc_plus4      (pc_plus4),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .jump          (jump),
        .jump_target   (jump_target),
        .exc           (exc),
        .stall         (stall),
        .bus           (bus.master),
        .fetch_cnt     (fetch_cnt)
    );

    always #5 clk = ~clk;

    assign pc_plus4       = pc + 32'd4;
    assign bus.imem_rdata = bus.imem_addr ^ XMASK;

    typedef struct {
        logic        br;
        logic [31:0] bt;
        logic        jmp;
        logic [31:0] jt;
        logic        ex;
        logic        stl;
        logic        rdy;
        logic        idr;
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_valid;
        logic [31:0] e_ifpc;
        logic [31:0] e_pc;
        logic [31:0] e_cnt;
    } vec_t;

    vec_t tbl [17];

    function automatic vec_t mk(
        input logic br, input logic [31:0] bt, input logic jmp, input logic [31:0] jt,
        input logic ex, input logic stl, input logic rdy, input logic idr,
        input logic e_req, input logic [31:0] e_addr, input logic e_valid,
        input logic [31:0] e_ifpc, input logic [31:0] e_pc, input logic [31:0] e_cnt);
        vec_t v;
        v.br = br; v.bt = bt; v.jmp = jmp; v.jt = jt; v.ex = ex; v.stl = stl;
        v.rdy = rdy; v.idr = idr; v.e_req = e_req; v.e_addr = e_addr;
        v.e_valid = e_valid; v.e_ifpc = e_ifpc; v.e_pc = e_pc; v.e_cnt = e_cnt;
        return v;
    endfunction

    task automatic chk(input string name, input int idx, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL step %0d %s: got %h want %h", idx, name, act, exp);
        end
    endtask

    task automatic check_reset(input int idx);
        chk("rst pc", idx, pc, RST_PC);
        chk("rst imem_req", idx, {31'd0, bus.imem_req}, 32'd0);
        chk("rst imem_addr", idx, bus.imem_addr, 32'd0);
        chk("rst if_valid", idx, {31'd0, bus.if_valid}, 32'd0);
        chk("rst if_instr", idx, bus.if_instr, 32'd0);
        chk("rst if_pc", idx, bus.if_pc, 32'd0);
        chk("rst fetch_cnt", idx, fetch_cnt, 32'd0);
    endtask

    // Entered and left at a falling edge; checks 1 time unit after the rise.
    task automatic step(input vec_t v, input int idx);
        branch_taken   = v.br;
        branch_target  = v.bt;
        jump           = v.jmp;
        jump_target    = v.jt;
        exc            = v.ex;
        stall          = v.stl;
        bus.imem_ready = v.rdy;
        bus.id_ready   = v.idr;
        @(posedge clk);
        #1;
        chk("imem_req", idx, {31'd0, bus.imem_req}, {31'd0, v.e_req});
        chk("imem_addr", idx, bus.imem_addr, v.e_addr);
        chk("if_valid", idx, {31'd0, bus.if_valid}, {31'd0, v.e_valid});
        chk("if_pc", idx, bus.if_pc, v.e_ifpc);
        chk("pc", idx, pc, v.e_pc);
        chk("fetch_cnt", idx, fetch_cnt, v.e_cnt);
        if (v.e_valid) begin
            chk("if_instr", idx, bus.if_instr, v.e_ifpc ^ XMASK);
        end
        @(negedge clk);
    endtask

    initial begin
        bus.imem_ready = 1'b0;
        bus.id_ready   = 1'b0;

        //       br bt            jmp jt            ex stl rdy idr | req addr          v  if_pc         pc            cnt
        tbl[0]  = mk(0, 32'h0,        0, 32'h0,        0, 0, 1, 1,  0, 32'h0,        0, 32'h0,        32'h0040_0000, 32'd0);
        tbl[1]  = mk(0, 32'h0,        0, 32'h0,        0, 0, 1, 1,  1, 32'h0040_0000, 0, 32'h0,        32'h0040_0000, 32'd0);
        tbl[2]  = mk(0, 32'h0,        0, 32'h0,        0, 0, 1, 1,  1, 32'h0040_0004, 1, 32'h0040_0000, 32'h0040_0004, 32'd0);
        tbl[3]  = mk(0, 32'h0,        0, 32'h0,        0, 0, 1, 1,  1, 32'h0040_0008, 1, 32'h0040_0004, 32'h0040_0008, 32'd1);
        tbl[4]  = mk(0, 32'h0,        0, 32'h0,        0, 0, 1, 1,  1, 32'h0040_000C, 1, 32'h0040_0008, 32'h0040_000C, 32'd2);
        // memory slows down; branch one cycle into the outstanding request
        tbl[5]  = mk(0, 32'h0,        0, 32'h0,        0, 0, 0, 1,  1, 32'h0040_000C, 0, 32'h0040_0008, 32'h0040_000C, 32'd3);
        tbl[6]  = mk(1, 32'h0040_0103, 0, 32'h0,       0, 0, 0, 1,  1, 32'h0040_000C, 0, 32'h0040_0008, 32'h0040_0100, 32'd3);
        tbl[7]  = mk(0, 32'h0,        0, 32'h0,        0, 0, 0, 1,  1, 32'h0040_000C, 0, 32'h0040_0008, 32'h0040_0100, 32'd3);
        tbl[8]  = mk(0, 32'h0,        0, 32'h0,        0, 0, 1, 1,  0, 32'h0040_000C, 0, 32'h0040_0008, 32'h0040_0100, 32'd3);
        tbl[9]  = mk(0, 32'h0,        0, 32'h0,        0, 0, 1, 1,  1, 32'h0040_0100, 0, 32'h0040_0008, 32'h0040_0100, 32'd3);
        tbl[10] = mk(0, 32'h0,        0, 32'h0,        0, 0, 1, 0,  1, 32'h0040_0104, 1, 32'h0040_0100, 32'h0040_0104, 32'd3);
        tbl[11] = mk(0, 32'h0,        0, 32'h0,        0, 0, 0, 0,  1, 32'h0040_0104, 1, 32'h0040_0100, 32'h0040_0104, 32'd3);
        // exc + jump + branch together: exception wins, buffer flushed
        tbl[12] = mk(1, 32'h5555_5554, 1, 32'h1234_5678, 1, 0, 0, 0, 1, 32'h0040_0104, 0, 32'h0040_0100, EXC_V,       32'd3);
        // jump in DRAIN (latest wins, low bits forced to 0), drain completes
        tbl[13] = mk(0, 32'h0,        1, 32'hFFFF_FFFE, 0, 0, 1, 0,  0, 32'h0040_0104, 0, 32'h0040_0100, 32'hFFFF_FFFC, 32'd3);
        tbl[14] = mk(0, 32'h0,        0, 32'h0,        0, 0, 1, 1,  1, 32'hFFFF_FFFC, 0, 32'h0040_0100, 32'hFFFF_FFFC, 32'd3);
        // completion at top of address space wraps pc; stall blocks chaining
        tbl[15] = mk(0, 32'h0,        0, 32'h0,        0, 1, 1, 1,  0, 32'hFFFF_FFFC, 1, 32'hFFFF_FFFC, 32'h0000_0000, 32'd3);
        tbl[16] = mk(0, 32'h0,        0, 32'h0,        0, 1, 1, 1,  0, 32'hFFFF_FFFC, 0, 32'hFFFF_FFFC, 32'h0000_0000, 32'd4);

        // Reset state.
        repeat (2) @(negedge clk);
        check_reset(-1);
        rst_n = 1'b1;

        for (int unsigned i = 0; i < 17; i++) begin
            step(tbl[i], int'(i));
        end

        // Buffered instruction held under stall with decode not ready.
        step(mk(0, 0, 0, 0, 0, 0, 1, 0,  1, 32'h0, 0, 32'hFFFF_FFFC, 32'h0, 32'd4), 100);
        step(mk(0, 0, 0, 0, 0, 1, 1, 0,  0, 32'h0, 1, 32'h0, 32'h4, 32'd4), 101);
        for (int unsigned i = 0; i < 5; i++) begin
            step(mk(0, 0, 0, 0, 0, 1, 1, 0,  0, 32'h0, 1, 32'h0, 32'h4, 32'd4), 102 + int'(i));
        end
        // Release: the next request starts at the following edge.
        step(mk(0, 0, 0, 0, 0, 0, 0, 1,  1, 32'h4, 0, 32'h0, 32'h4, 32'd5), 107);
        // Branch with the request outstanding -> DRAIN.
        step(mk(1, 32'h200, 0, 0, 0, 0, 0, 1,  1, 32'h4, 0, 32'h0, 32'h200, 32'd5), 108);

        // Asynchronous reset in DRAIN takes effect immediately.
        branch_taken   = 1'b0;
        bus.imem_ready = 1'b0;
        bus.id_ready   = 1'b0;
        rst_n = 1'b0;
        #1;
        check_reset(109);
        @(negedge clk);
        rst_n = 1'b1;
        step(mk(0, 0, 0, 0, 0, 0, 0, 0,  0, 32'h0, 0, 32'h0, RST_PC, 32'd0), 110);
        step(mk(0, 0, 0, 0, 0, 0, 0, 0,  1, RST_PC, 0, 32'h0, RST_PC, 32'd0), 111);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
